// File: rtl/udp_packet_rx.sv
// udp_packet_rx: GMII receive path; strips preamble/SFD, parses Ethernet,
// IPv4 and UDP headers, filters on local MAC/IP/port and streams the payload.
// Ports: clk/rst; i_rx_dv/i_rx_er/i_rx_data PHY byte stream;
// i_local_mac/ip/port filter values; o_udp_data/vl/sop/eop payload stream;
// o_src_mac/ip/port, o_udp_len frame fields; o_done/o_ok/o_err status
// strobe; o_state debug copy of the FSM state.
module udp_packet_rx #(
    parameter bit ACCEPT_BCAST  = 1'b1,
    parameter bit CHECK_IP_CSUM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rx_dv,
    input  logic        i_rx_er,
    input  logic [7:0]  i_rx_data,
    input  logic [47:0] i_local_mac,
    input  logic [31:0] i_local_ip,
    input  logic [15:0] i_local_port,
    output logic [7:0]  o_udp_data,
    output logic        o_udp_vl,
    output logic        o_udp_sop,
    output logic        o_udp_eop,
    output logic [47:0] o_src_mac,
    output logic [31:0] o_src_ip,
    output logic [15:0] o_src_port,
    output logic [15:0] o_udp_len,
    output logic        o_done,
    output logic        o_ok,
    output logic [2:0]  o_err,
    output logic [3:0]  o_state
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PRE   = 4'd1,
        S_ETH   = 4'd2,
        S_IP    = 4'd3,
        S_UDP   = 4'd4,
        S_PAY   = 4'd5,
        S_PAD   = 4'd6,
        S_CHECK = 4'd7,
        S_DROP  = 4'd8
    } state_t;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_GOOD = 32'hDEBB_20E3;

    state_t      state_q, state_n;
    logic [4:0]  cnt_q;
    logic [39:0] sh_q;
    logic [47:0] sh_n;
    logic [15:0] fld16;
    logic [31:0] crc_q;
    logic [19:0] csum_q;
    logic [19:0] ck_sum;
    logic [16:0] ck_f1;
    logic [15:0] ck_f2;
    logic [15:0] rem_q;
    logic [2:0]  hdr_q;
    logic [2:0]  det;
    logic [2:0]  code;
    logic        er7_q;
    logic        frame_q;
    logic        mac_ok;
    logic        csum_ok;
    logic        sfd;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // sh_n holds the last six received bytes, newest in the low byte
    assign sh_n   = {sh_q, i_rx_data};
    assign fld16  = sh_n[15:0];

    // running IP header sum; folded twice to absorb the end-around carry
    assign ck_sum = csum_q + {4'd0, fld16};
    assign ck_f1  = {1'b0, ck_sum[15:0]} + {13'd0, ck_sum[19:16]};
    assign ck_f2  = ck_f1[15:0] + {15'd0, ck_f1[16]};

    assign csum_ok = !CHECK_IP_CSUM || (ck_f2 == 16'hFFFF);
    assign mac_ok  = (sh_n == i_local_mac) || (ACCEPT_BCAST && (&sh_n));
    assign sfd     = (state_n == S_ETH) && (state_q != S_ETH);

    always_comb begin
        state_n = state_q;
        det     = 3'd0;
        unique case (state_q)
            S_IDLE: begin
                if (i_rx_dv && i_rx_data == 8'h55)
                    state_n = S_PRE;
                else if (i_rx_dv && i_rx_data == 8'hD5)
                    state_n = S_ETH;
            end
            S_PRE: begin
                if (!i_rx_dv)
                    state_n = S_IDLE;
                else if (i_rx_data == 8'hD5)
                    state_n = S_ETH;
                else if (i_rx_data != 8'h55 || cnt_q == 5'd7)
                    state_n = S_DROP;
            end
            S_ETH: begin
                if (!i_rx_dv) begin
                    state_n = S_CHECK;
                end else begin
                    if (cnt_q == 5'd5 && !mac_ok)
                        det = 3'd2;
                    if (cnt_q == 5'd13 && fld16 != 16'h0800)
                        det = 3'd3;
                    if (det != 3'd0)
                        state_n = S_DROP;
                    else if (cnt_q == 5'd13)
                        state_n = S_IP;
                end
            end
            S_IP: begin
                if (!i_rx_dv) begin
                    state_n = S_CHECK;
                end else begin
                    if (cnt_q == 5'd0 && i_rx_data != 8'h45)
                        det = 3'd3;
                    if (cnt_q == 5'd9 && i_rx_data != 8'h11)
                        det = 3'd3;
                    if (cnt_q == 5'd19) begin
                        if (sh_n[31:0] != i_local_ip)
                            det = 3'd5;
                        else if (!csum_ok)
                            det = 3'd4;
                    end
                    if (det != 3'd0)
                        state_n = S_DROP;
                    else if (cnt_q == 5'd19)
                        state_n = S_UDP;
                end
            end
            S_UDP: begin
                if (!i_rx_dv) begin
                    state_n = S_CHECK;
                end else begin
                    if (cnt_q == 5'd3 && fld16 != i_local_port)
                        det = 3'd6;
                    if (cnt_q == 5'd5 && fld16 < 16'd8)
                        det = 3'd3;
                    if (det != 3'd0)
                        state_n = S_DROP;
                    else if (cnt_q == 5'd7)
                        state_n = (rem_q == 16'd0) ? S_PAD : S_PAY;
                end
            end
            S_PAY: begin
                if (!i_rx_dv)
                    state_n = S_CHECK;
                else if (rem_q == 16'd1)
                    state_n = S_PAD;
            end
            S_PAD: begin
                if (!i_rx_dv)
                    state_n = S_CHECK;
            end
            S_CHECK: state_n = S_IDLE;
            S_DROP: begin
                // a bad preamble never reached the SFD: leave silently
                if (!i_rx_dv)
                    state_n = frame_q ? S_CHECK : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 5'd0;
            sh_q       <= 40'd0;
            crc_q      <= CRC_INIT;
            csum_q     <= 20'd0;
            rem_q      <= 16'd0;
            hdr_q      <= 3'd0;
            er7_q      <= 1'b0;
            frame_q    <= 1'b0;
            o_udp_data <= 8'd0;
            o_udp_vl   <= 1'b0;
            o_udp_sop  <= 1'b0;
            o_udp_eop  <= 1'b0;
            o_src_mac  <= 48'd0;
            o_src_ip   <= 32'd0;
            o_src_port <= 16'd0;
            o_udp_len  <= 16'd0;
        end else begin
            o_udp_vl  <= 1'b0;
            o_udp_sop <= 1'b0;
            o_udp_eop <= 1'b0;
            if (i_rx_dv)
                sh_q <= sh_n[39:0];
            if (state_n != state_q)
                cnt_q <= (state_n == S_PRE) ? 5'd1 : 5'd0;
            else if (i_rx_dv)
                cnt_q <= cnt_q + 5'd1;
            if (sfd) begin
                crc_q   <= CRC_INIT;
                hdr_q   <= 3'd0;
                er7_q   <= 1'b0;
                frame_q <= 1'b1;
            end else begin
                if (frame_q && i_rx_dv)
                    crc_q <= crc_byte(crc_q, i_rx_data);
                if (det != 3'd0)
                    hdr_q <= det;
                if (frame_q && i_rx_er)
                    er7_q <= 1'b1;
                if (!i_rx_dv &&
                    (state_q inside {S_ETH, S_IP, S_UDP, S_PAY}))
                    er7_q <= 1'b1;
                if (state_q == S_CHECK || state_n == S_IDLE)
                    frame_q <= 1'b0;
            end
            if (state_q != S_IP)
                csum_q <= 20'd0;
            else if (i_rx_dv && cnt_q[0])
                csum_q <= ck_sum;
            if (i_rx_dv) begin
                if (state_q == S_ETH && cnt_q == 5'd11)
                    o_src_mac <= sh_n;
                if (state_q == S_IP && cnt_q == 5'd15)
                    o_src_ip <= sh_n[31:0];
                if (state_q == S_UDP && cnt_q == 5'd1)
                    o_src_port <= fld16;
                if (state_q == S_UDP && cnt_q == 5'd5 && det == 3'd0) begin
                    o_udp_len <= fld16 - 16'd8;
                    rem_q     <= fld16 - 16'd8;
                end
                if (state_q == S_PAY) begin
                    o_udp_data <= i_rx_data;
                    o_udp_vl   <= 1'b1;
                    o_udp_sop  <= (rem_q == o_udp_len);
                    o_udp_eop  <= (rem_q == 16'd1);
                    rem_q      <= rem_q - 16'd1;
                end
            end
        end
    end

    // header error beats truncation/PHY error, which beats a bad FCS
    always_comb begin
        code = 3'd0;
        if (hdr_q != 3'd0)
            code = hdr_q;
        else if (er7_q)
            code = 3'd7;
        else if (crc_q != CRC_GOOD)
            code = 3'd1;
    end

    assign o_done  = (state_q == S_CHECK);
    assign o_err   = o_done ? code : 3'd0;
    assign o_ok    = o_done && (code == 3'd0);
    assign o_state = state_q;

endmodule
